// File: rtl/mem_load_store_requester.sv
// Memory-request initiator: turns one pipeline load/store into a memory_io request, returns aligned/extended data.
// Latency: request one cycle after accept; done one cycle after the matching response (N+3 against a next-cycle responder).
// Backpressure: op_ready only in IDLE, so one request is outstanding; responses cannot be stalled and are never buffered.
// Optional build macro MEM_REQUESTER_STATS_EN adds stat_loads / stat_stores / stat_stray_rsp counters.

package memory_io_pkg;
  localparam int unsigned USER_TAG_W = 4;

  typedef struct packed {
    logic                  valid;
    logic [3:0]            do_read;
    logic [3:0]            do_write;
    logic [31:0]           addr;
    logic [31:0]           data;
    logic [USER_TAG_W-1:0] user_tag;
  } memory_io_req32;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           data;
    logic [USER_TAG_W-1:0] user_tag;
  } memory_io_rsp32;
endpackage

module mem_load_store_requester #(
  parameter int unsigned timeout_cycles   = 16,
  parameter bit          enable_tag_check = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           op_valid,
  output logic                           op_ready,
  input  logic                           op_is_store,
  input  logic [1:0]                     op_size,
  input  logic                           op_unsigned,
  input  logic [31:0]                    op_addr,
  input  logic [31:0]                    op_wdata,
  input  logic [4:0]                     op_rd,
  output memory_io_pkg::memory_io_req32  req,
  input  memory_io_pkg::memory_io_rsp32  rsp,
  output logic                           done_valid,
  output logic [31:0]                    done_rdata,
  output logic [4:0]                     done_rd,
  output logic                           done_is_store,
  output logic                           misaligned_err,
  output logic                           timeout_err
`ifdef MEM_REQUESTER_STATS_EN
  ,
  output logic [31:0]                    stat_loads,
  output logic [31:0]                    stat_stores,
  output logic [31:0]                    stat_stray_rsp
`endif
);
  import memory_io_pkg::*;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Counter must hold timeout_cycles-1; expiry is judged on the last WAIT cycle.
  localparam int unsigned    CNT_W    = $clog2(timeout_cycles + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

  state_t                state, state_nx;
  logic [USER_TAG_W-1:0] tag;
  logic [CNT_W-1:0]      cnt;

  // Attributes of the outstanding op, needed when the response returns.
  logic [1:0]            lat_size;
  logic                  lat_unsigned;
  logic [1:0]            lat_lane;
  logic [4:0]            lat_rd;
  logic                  lat_is_store;

  logic                  accept;
  logic                  misaligned;
  logic                  issue;
  logic                  rsp_match;
  logic                  expire;
  logic [3:0]            be_base;
  logic [3:0]            be_mask;
  logic [31:0]           st_data;
  logic [31:0]           ld_shift;
  logic [31:0]           ld_data;

  assign accept = op_valid && op_ready;

  // Size/alignment decode of the offered op: byte enables, store lane replication, legality.
  always_comb begin
    misaligned = 1'b0;
    be_base    = 4'b1111;
    st_data    = op_wdata;
    case (op_size)
      2'b00: begin
        be_base = 4'b0001;
        st_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = op_addr[0];
        be_base    = 4'b0011;
        st_data    = {2{op_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |op_addr[1:0];
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
    be_mask = be_base << op_addr[1:0];
  end

  // Load result: bring the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    ld_shift = rsp.data >> {lat_lane, 3'b000};
    case (lat_size)
      2'b00:   ld_data = {{24{~lat_unsigned & ld_shift[7]}},  ld_shift[7:0]};
      2'b01:   ld_data = {{16{~lat_unsigned & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM next state: leave IDLE on a legal accept, leave WAIT on match or expiry.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (issue)              state_nx = S_WAIT;
      S_WAIT:  if (rsp_match || expire) state_nx = S_IDLE;
      default:                          state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: handshake and the per-cycle decisions feeding the datapath registers.
  always_comb begin
    op_ready  = (state == S_IDLE);
    issue     = accept && !misaligned;
    rsp_match = (state == S_WAIT) && rsp.valid &&
                (!enable_tag_check || (rsp.user_tag == tag));
    expire    = (state == S_WAIT) && !rsp_match && (cnt == CNT_LAST);
  end

  // Registered request, completion pulses, tag and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      req            <= '0;
      tag            <= '0;
      cnt            <= '0;
      lat_size       <= '0;
      lat_unsigned   <= 1'b0;
      lat_lane       <= '0;
      lat_rd         <= '0;
      lat_is_store   <= 1'b0;
      done_valid     <= 1'b0;
      done_rdata     <= '0;
      done_rd        <= '0;
      done_is_store  <= 1'b0;
      misaligned_err <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      req.valid <= issue;
      if (issue) begin
        req.do_read   <= op_is_store ? 4'b0000 : be_mask;
        req.do_write  <= op_is_store ? be_mask : 4'b0000;
        req.addr      <= op_addr;
        req.data      <= op_is_store ? st_data : 32'd0;
        req.user_tag  <= tag + 1'b1;
        tag           <= tag + 1'b1;
        lat_size      <= op_size;
        lat_unsigned  <= op_unsigned;
        lat_lane      <= op_addr[1:0];
        lat_rd        <= op_rd;
        lat_is_store  <= op_is_store;
      end
      // Counts WAIT cycles only; stray responses do not touch it.
      cnt <= ((state == S_WAIT) && !rsp_match && !expire) ? cnt + 1'b1 : '0;

      done_valid     <= rsp_match;
      done_rdata     <= (rsp_match && !lat_is_store) ? ld_data : 32'd0;
      done_rd        <= rsp_match ? lat_rd : 5'd0;
      done_is_store  <= rsp_match && lat_is_store;
      misaligned_err <= accept && misaligned;
      timeout_err    <= expire;
    end
  end

`ifdef MEM_REQUESTER_STATS_EN
  // Wrapping event counters: completed loads/stores and responses that matched nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads     <= '0;
      stat_stores    <= '0;
      stat_stray_rsp <= '0;
    end else begin
      if (rsp_match && !lat_is_store) stat_loads  <= stat_loads + 32'd1;
      if (rsp_match &&  lat_is_store) stat_stores <= stat_stores + 32'd1;
      if (rsp.valid && !rsp_match)    stat_stray_rsp <= stat_stray_rsp + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_load_store_requester.sv
// Bench for mem_load_store_requester: directed ops against a next-cycle memory model.
// Expected requests and completion events are queued at accept time; a monitor pops them when the DUT drives them.
module tb_mem_load_store_requester;
  import memory_io_pkg::*;

  localparam int TO     = 6;
  localparam int K_DONE = 0;
  localparam int K_MIS  = 1;
  localparam int K_TO   = 2;
  localparam int K_NONE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic        op_is_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [4:0]  op_rd;
  memory_io_req32 req;
  memory_io_rsp32 rsp;
  memory_io_rsp32 auto_rsp;
  memory_io_rsp32 man_rsp;
  logic        silent;
  logic        done_valid;
  logic [31:0] done_rdata;
  logic [4:0]  done_rd;
  logic        done_is_store;
  logic        misaligned_err;
  logic        timeout_err;
`ifdef MEM_REQUESTER_STATS_EN
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;
  logic [31:0] stat_stray_rsp;
`endif

  assign rsp = silent ? man_rsp : auto_rsp;

  mem_load_store_requester #(.timeout_cycles(TO), .enable_tag_check(1'b1)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_is_store(op_is_store),
    .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd),
    .req(req), .rsp(rsp),
    .done_valid(done_valid), .done_rdata(done_rdata), .done_rd(done_rd),
    .done_is_store(done_is_store), .misaligned_err(misaligned_err),
    .timeout_err(timeout_err)
`ifdef MEM_REQUESTER_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_stray_rsp(stat_stray_rsp)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    memory_io_req32 r;
    int             cyc;
  } exp_req_t;

  typedef struct {
    int          kind;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        st;
    int          cyc;
  } exp_ev_t;

  exp_req_t req_q[$];
  exp_ev_t  ev_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [USER_TAG_W-1:0] exp_tag;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory model: answers a request on the following cycle, echoing its tag.
  initial begin : responder
    logic [31:0]    mem [0:255];
    logic           cap;
    memory_io_req32 capr;
    int             idx;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'hDEADBEEF;   // 0x100
    mem[8'h41] = 32'h80123456;   // 0x104
    auto_rsp = '0;
    forever begin
      @(negedge clk);
      cap  = req.valid && !silent;
      capr = req;
      @(posedge clk);
      #1;
      if (cap) begin
        idx = int'(capr.addr[9:2]);
        auto_rsp.valid    = 1'b1;
        auto_rsp.data     = mem[idx];
        auto_rsp.user_tag = capr.user_tag;
        for (int b = 0; b < 4; b++)
          if (capr.do_write[b]) mem[idx][8*b +: 8] = capr.data[8*b +: 8];
      end else begin
        auto_rsp.valid = 1'b0;
      end
    end
  end

  // Scoreboard monitor: compares every request and every completion/error pulse.
  exp_req_t mon_er;
  exp_ev_t  mon_ev;
  int       mon_kind;
  always @(negedge clk) begin
    if (req.valid) begin
      if (req_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_req: got addr 0x%0h tag %0d at cycle %0d, expected none", req.addr, req.user_tag, cyc);
      end else begin
        mon_er = req_q.pop_front();
        check("req_fields", 96'(req), 96'(mon_er.r));
        check("req_cycle", 96'(cyc), 96'(mon_er.cyc));
      end
    end
    if (done_valid || misaligned_err || timeout_err) begin
      if (32'(done_valid) + 32'(misaligned_err) + 32'(timeout_err) > 1) mon_kind = 9;
      else if (done_valid)     mon_kind = K_DONE;
      else if (misaligned_err) mon_kind = K_MIS;
      else                     mon_kind = K_TO;
      if (ev_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", mon_kind, cyc);
      end else begin
        mon_ev = ev_q.pop_front();
        check("event_kind", 96'(mon_kind), 96'(mon_ev.kind));
        check("event_cycle", 96'(cyc), 96'(mon_ev.cyc));
        if (mon_ev.kind == K_DONE)
          check("done_payload", {58'd0, done_rdata, done_rd, done_is_store},
                {58'd0, mon_ev.rdata, mon_ev.rd, mon_ev.st});
      end
    end
  end

  // Offer one op, wait (bounded) for acceptance, queue the expected request and event.
  task automatic do_op(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input int kind, input logic [31:0] exp_rdata,
                       input logic [3:0] mask, input logic [31:0] exp_data, output int e);
    exp_req_t er;
    exp_ev_t  ev;
    op_valid = 1'b1; op_is_store = st; op_size = sz; op_unsigned = uns;
    op_addr = a; op_wdata = wd; op_rd = rd;
    for (int i = 0; i < 64 && !op_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!op_ready) begin
      n_checks++;
      $display("FAIL op_ready_wait: got op_ready 0 after 64 cycles, expected 1");
      op_valid = 1'b0;
      e = cyc;
      return;
    end
    @(posedge clk); #1;
    e = cyc;
    op_valid = 1'b0;
    if (kind != K_MIS) begin
      exp_tag = exp_tag + 1'b1;
      er.r.valid    = 1'b1;
      er.r.do_read  = st ? 4'b0000 : mask;
      er.r.do_write = st ? mask : 4'b0000;
      er.r.addr     = a;
      er.r.data     = exp_data;
      er.r.user_tag = exp_tag;
      er.cyc        = e;
      req_q.push_back(er);
    end
    if (kind != K_NONE) begin
      ev.kind  = kind;
      ev.rdata = exp_rdata;
      ev.rd    = rd;
      ev.st    = st;
      ev.cyc   = (kind == K_DONE) ? e + 2 : (kind == K_MIS) ? e : e + TO;
      ev_q.push_back(ev);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units, expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    int e;
    int prev;
    logic [USER_TAG_W-1:0] stale_tag;
    logic [USER_TAG_W-1:0] rt;
    reset = 1'b1; op_valid = 1'b0; op_is_store = 1'b0; op_size = 2'b00;
    op_unsigned = 1'b0; op_addr = '0; op_wdata = '0; op_rd = '0;
    silent = 1'b0; man_rsp = '0; exp_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_op_ready", 96'(op_ready), 96'd1);
    check("reset_req", 96'(req), 96'd0);
    check("reset_done_valid", 96'(done_valid), 96'd0);
    check("reset_done_rdata", 96'(done_rdata), 96'd0);
    check("reset_done_rd", 96'(done_rd), 96'd0);
    check("reset_done_is_store", 96'(done_is_store), 96'd0);
    check("reset_misaligned_err", 96'(misaligned_err), 96'd0);
    check("reset_timeout_err", 96'(timeout_err), 96'd0);

    // Aligned loads/stores: st, size, unsigned, addr, wdata, rd, kind, rdata, mask, req.data
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,       5'd5,  K_DONE, 32'hDEADBEEF, 4'b1111, 32'h0,       e);
    do_op(1'b0, 2'b00, 1'b0, 32'h107, 32'h0,       5'd6,  K_DONE, 32'hFFFFFF80, 4'b1000, 32'h0,       e);
    do_op(1'b0, 2'b00, 1'b1, 32'h107, 32'h0,       5'd7,  K_DONE, 32'h00000080, 4'b1000, 32'h0,       e);
    do_op(1'b1, 2'b01, 1'b0, 32'h10A, 32'h0000BEEF, 5'd8, K_DONE, 32'h0,        4'b1100, 32'hBEEFBEEF, e);
    do_op(1'b0, 2'b10, 1'b0, 32'h108, 32'h0,       5'd9,  K_DONE, 32'hBEEF0000, 4'b1111, 32'h0,       e);
    do_op(1'b0, 2'b01, 1'b0, 32'h10A, 32'h0,       5'd10, K_DONE, 32'hFFFFBEEF, 4'b1100, 32'h0,       e);
    do_op(1'b1, 2'b00, 1'b0, 32'h109, 32'h000000A5, 5'd11, K_DONE, 32'h0,       4'b0010, 32'hA5A5A5A5, e);
    do_op(1'b0, 2'b10, 1'b0, 32'h108, 32'h0,       5'd12, K_DONE, 32'hBEEFA500, 4'b1111, 32'h0,       e);
    do_op(1'b0, 2'b01, 1'b1, 32'h108, 32'h0,       5'd13, K_DONE, 32'h0000A500, 4'b0011, 32'h0,       e);
    do_op(1'b1, 2'b10, 1'b0, 32'h10C, 32'h12345678, 5'd14, K_DONE, 32'h0,       4'b1111, 32'h12345678, e);
    do_op(1'b0, 2'b00, 1'b0, 32'h10D, 32'h0,       5'd15, K_DONE, 32'h00000056, 4'b0010, 32'h0,       e);

    // Illegal / misaligned ops: error pulse, no request, still ready.
    do_op(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd1, K_MIS, 32'h0, 4'b0000, 32'h0, e);
    check("misaligned_op_ready", 96'(op_ready), 96'd1);
    do_op(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 5'd2, K_MIS, 32'h0, 4'b0000, 32'h0, e);
    do_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 5'd3, K_MIS, 32'h0, 4'b0000, 32'h0, e);
    do_op(1'b1, 2'b10, 1'b0, 32'h102, 32'h5, 5'd4, K_MIS, 32'h0, 4'b0000, 32'h0, e);
    check("misaligned_req_valid", 96'(req.valid), 96'd0);

    // Silent responder: timeout, then a stale response in IDLE and in WAIT.
    silent = 1'b1;
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd16, K_TO, 32'h0, 4'b1111, 32'h0, e);
    stale_tag = exp_tag;
    repeat (TO + 1) begin @(posedge clk); #1; end
    man_rsp = '{valid: 1'b1, data: 32'h55555555, user_tag: stale_tag};
    @(posedge clk); #1;
    man_rsp = '0;
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd17, K_DONE, 32'hCAFEF00D, 4'b1111, 32'h0, e);
    man_rsp = '{valid: 1'b1, data: 32'h11111111, user_tag: stale_tag};
    @(posedge clk); #1;
    man_rsp = '{valid: 1'b1, data: 32'hCAFEF00D, user_tag: exp_tag};
    @(posedge clk); #1;
    man_rsp = '0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset while waiting: abandoned, outputs cleared, late response ignored.
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd18, K_NONE, 32'h0, 4'b1111, 32'h0, e);
    rt = exp_tag;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_tag = '0;
    check("midreset_op_ready", 96'(op_ready), 96'd1);
    check("midreset_req", 96'(req), 96'd0);
    check("midreset_pulses", 96'({done_valid, misaligned_err, timeout_err}), 96'd0);
    check("midreset_done_data", 96'({done_rdata, done_rd, done_is_store}), 96'd0);
    man_rsp = '{valid: 1'b1, data: 32'h33333333, user_tag: rt};
    @(posedge clk); #1;
    man_rsp = '0;
    repeat (3) begin @(posedge clk); #1; end
    silent = 1'b0;

    // Back-to-back loads through a tag wrap: one accept every 3 cycles.
    prev = 0;
    for (int i = 0; i < 18; i++) begin
      do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'(i), K_DONE, 32'hDEADBEEF, 4'b1111, 32'h0, e);
      if (i > 0) check("b2b_spacing", 96'(e - prev), 96'd3);
      prev = e;
    end

    repeat (5) begin @(posedge clk); #1; end
    check("req_queue_drained", 96'(req_q.size()), 96'd0);
    check("event_queue_drained", 96'(ev_q.size()), 96'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_load_store_requester.md
Name: mem_load_store_requester

Overview:
- Initiator end of the 32-bit memory_io protocol: accepts one load/store op at a time from the pipeline and issues a memory_io_req32.
- Waits for the matching memory_io_rsp32, then returns aligned, extended load data or a store ack.
- Sits between the execute/MEM stage and any memory32-style responder (single-cycle or slower).
- Keeps one request outstanding, with tag matching and a response timeout.

Parameters:
- timeout_cycles, 16: WAIT cycles without a matching response before aborting; must be at least 2.
- enable_tag_check, 1: 1 means rsp.user_tag must equal the issued tag; 0 means any rsp.valid in WAIT completes the op.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  op offered
- op_ready  out  1  block can accept; high only in IDLE
- op_is_store  in  1  1 = store, 0 = load
- op_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- op_unsigned  in  1  zero-extend the load result (LBU/LHU)
- op_addr  in  32  byte address
- op_wdata  in  32  store data, right-justified
- op_rd  in  5  destination register, returned with the result
- req  out  memory_io_req32  request to memory
- rsp  in  memory_io_rsp32  response from memory
- done_valid  out  1  one-cycle completion pulse
- done_rdata  out  32  load result; 0 for stores
- done_rd  out  5  op_rd of the completed op
- done_is_store  out  1  completed op was a store
- misaligned_err  out  1  one-cycle pulse for an illegal or misaligned op
- timeout_err  out  1  one-cycle pulse when an op is aborted

Behaviour:
- Reset (sync, active-high): FSM to IDLE.
  - req: all fields 0 (valid, do_read, do_write, addr, data, user_tag).
  - done_valid, done_rdata, done_rd, done_is_store, misaligned_err, timeout_err = 0.
  - tag = 0; timeout counter = 0.
- FSM states:
  - IDLE: op_ready = 1.
  - WAIT: op_ready = 0.
- Accept condition: op_valid && op_ready at cycle N.
- Alignment check at accept:
  - Misaligned if op_size = 11, half with addr[0] = 1, or word with addr[1:0] != 0.
  - Misaligned op: no request issued; misaligned_err = 1 at N+1; FSM stays IDLE.
- Legal op at accept:
  - Latch size, unsigned, lane = addr[1:0], rd and is_store.
  - tag <= tag + 1, wrapping at the user_tag field width; the new tag value is driven on req.user_tag.
  - FSM -> WAIT.
- Request is registered:
  - req.valid = 1 for exactly the cycle N+1, then 0.
  - req.addr = op_addr, full byte address.
- Byte enables, drawn from 4'b0001, 4'b0011 or 4'b1111 by size, shifted left by lane:
  - Loads: req.do_read = mask, do_write = 0.
  - Stores: req.do_write = mask, do_read = 0.
- Store data placement:
  - byte: replicated into all 4 lanes.
  - half: replicated into both halves.
  - word: as-is.
- WAIT, response matching:
  - Counter increments each cycle.
  - Match = rsp.valid && (tag equal, or enable_tag_check = 0).
- On a match at cycle M:
  - At M+1: done_valid = 1 for one cycle, with done_rd and done_is_store.
  - done_rdata: for a load, rsp.data >> (lane*8), truncated to the op size, then sign-extended, or zero-extended if unsigned; for a store, 0.
  - FSM -> IDLE at M+1, so op_ready = 1 in the same cycle as done_valid.
- Timeout: counter reaches timeout_cycles with no match -> timeout_err = 1 for one cycle, no done_valid, FSM -> IDLE.
- Late response after a timeout: tag has already advanced on the next issue, so it is ignored when enable_tag_check = 1.
- Stray responses (rsp.valid in IDLE, or tag mismatch in WAIT) are ignored and do not reset the counter.
- Latency against memory32, which responds at N+2:
  - done_valid at N+3.
  - Back-to-back ops accepted every 3 cycles.
- Reset mid-WAIT: request abandoned, no done or error pulse, tag = 0.
  - A response arriving afterwards in IDLE is ignored.

Optional Feature:
- Macro: MEM_REQUESTER_STATS_EN.
- Defined: adds three outputs, each a 32-bit wrapping counter cleared by reset:
  - stat_loads: increments on each load done_valid.
  - stat_stores: increments on each store done_valid.
  - stat_stray_rsp: increments on each ignored rsp.valid.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Word load, addr 0x100, memory word 0xDEADBEEF, op accepted at cycle N:
  - req.valid = 1 only at N+1, do_read = 1111.
  - done_valid at N+3, done_rdata = 0xDEADBEEF, done_rd echoed.
- Byte load, addr 0x103, memory word 0x80123456:
  - Signed: done_rdata = 0xFFFFFF80.
  - Unsigned: done_rdata = 0x00000080.
  - do_read = 1000 in both cases.
- Half store, addr 0x102, wdata 0x0000BEEF:
  - do_write = 1100, req.data = 0xBEEFBEEF.
  - Subsequent word load from 0x100 returns 0xBEEF0000 when the word was previously 0.
- Misaligned word load at 0x101:
  - misaligned_err = 1 for one cycle; req.valid stays 0; op_ready remains 1.
- Responder stubbed silent:
  - timeout_err = 1 exactly timeout_cycles cycles after req.valid; no done_valid.
  - A later stale rsp with the old tag is ignored; the next op completes normally.
- Reset asserted while in WAIT:
  - All outputs return to 0 next cycle; op_ready = 1.
  - A response arriving afterwards produces no done_valid.
